// File: rtl/tlb_fill_if.sv
// Lookup and page-table-walker signal bundle between a requester/walker and tlb_fill.
// Handshake: the requester holds lookup_valid/lookup_addr until lookup_hit or lookup_fault;
// tlb_fill holds walk_req_valid/walk_req_addr constant until a one-cycle walk_resp_valid pulse.
interface tlb_fill_if;
  logic        lookup_valid;
  logic [63:0] lookup_addr;
  logic        lookup_hit;
  logic [63:0] lookup_paddr;
  logic [7:0]  lookup_perms;
  logic        lookup_fault;
  logic        walk_req_valid;
  logic [63:0] walk_req_addr;
  logic        walk_resp_valid;
  logic [63:0] walk_resp_addr;
  logic [7:0]  walk_resp_perms;

  modport master (
    output lookup_valid, lookup_addr, walk_resp_valid, walk_resp_addr, walk_resp_perms,
    input  lookup_hit, lookup_paddr, lookup_perms, lookup_fault, walk_req_valid, walk_req_addr
  );

  modport slave (
    input  lookup_valid, lookup_addr, walk_resp_valid, walk_resp_addr, walk_resp_perms,
    output lookup_hit, lookup_paddr, lookup_perms, lookup_fault, walk_req_valid, walk_req_addr
  );
endinterface

// File: rtl/tlb_fill.sv
// Fully-associative 4 KiB TLB with a single outstanding page-table walk on miss.
// Combinational hit path; fills go to the lowest free entry, else a round-robin victim.
module tlb_fill #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [63:0] root_pt_addr,
  tlb_fill_if.slave   bus,
  output logic [1:0]  o_dbg_state
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MISS  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e           r_state;
  logic [ENTRIES-1:0] r_valid;
  logic [51:0]      r_vpn   [ENTRIES];
  logic [51:0]      r_ppn   [ENTRIES];
  logic [7:0]       r_perms [ENTRIES];
  logic [IDX_W-1:0] r_rr;
  logic             r_discard;
  logic [63:0]      r_miss_addr;
  logic [63:0]      r_root;

  logic             w_flush;
  logic             w_match;
  logic             w_hit;
  logic             w_fault;
  logic             w_fill;
  logic             w_has_free;
  logic [IDX_W-1:0] w_match_idx;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_victim;
  logic [51:0]      w_vpn;
  logic             w_unused;

  assign w_vpn    = bus.lookup_addr[63:12];
  assign w_unused = ^bus.walk_resp_addr[11:0];
  // An SATP root change behaves exactly like sfence.vma.
  assign w_flush  = flush | (root_pt_addr != r_root);

  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    w_has_free  = 1'b0;
    w_free_idx  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!w_match && r_valid[i] && (r_vpn[i] == w_vpn)) begin
        w_match     = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!w_has_free && !r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_victim = w_has_free ? w_free_idx : r_rr;

  assign w_hit   = reset && (r_state == S_IDLE) && bus.lookup_valid && w_match && !w_flush;
  assign w_fault = reset && (r_state == S_FAULT) && bus.lookup_valid &&
                   (w_vpn == r_miss_addr[63:12]);
  // A discarded walk or a coincident flush consumes the response with neither fill nor fault.
  assign w_fill  = (r_state == S_MISS) && bus.walk_resp_valid && bus.walk_resp_perms[0] &&
                   !r_discard && !w_flush;

  assign bus.lookup_hit     = w_hit;
  assign bus.lookup_paddr   = w_hit ? {r_ppn[w_match_idx], bus.lookup_addr[11:0]} : '0;
  assign bus.lookup_perms   = w_hit ? r_perms[w_match_idx] : '0;
  assign bus.lookup_fault   = w_fault;
  assign bus.walk_req_valid = (r_state == S_MISS);
  assign bus.walk_req_addr  = (r_state == S_MISS) ? r_miss_addr : '0;
  assign o_dbg_state        = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_rr        <= '0;
      r_discard   <= 1'b0;
      r_miss_addr <= '0;
      r_root      <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_vpn[i]   <= '0;
        r_ppn[i]   <= '0;
        r_perms[i] <= '0;
      end
    end else begin
      r_root <= root_pt_addr;

      case (r_state)
        S_IDLE: begin
          if (bus.lookup_valid && !w_hit) begin
            r_miss_addr <= bus.lookup_addr;
            r_discard   <= 1'b0;
            r_state     <= S_MISS;
          end
        end
        S_MISS: begin
          if (bus.walk_resp_valid) begin
            r_discard <= 1'b0;
            if (!r_discard && !w_flush && !bus.walk_resp_perms[0]) begin
              r_state <= S_FAULT;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_flush) begin
            r_discard <= 1'b1;
          end
        end
        S_FAULT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_fill) begin
        r_vpn[w_victim]   <= r_miss_addr[63:12];
        r_ppn[w_victim]   <= bus.walk_resp_addr[63:12];
        r_perms[w_victim] <= bus.walk_resp_perms;
        if (!w_has_free) begin
          r_rr <= (r_rr == IDX_W'(ENTRIES - 1)) ? '0 : r_rr + 1'b1;
        end
      end

      if (w_flush) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[w_victim] <= 1'b1;
      end
    end
  end
endmodule
